// File: rtl/rx_pkg.sv
// Shared definitions for the RX frame FIFO: FSM state encoding and the
// width of one stored entry (data word, byte lanes, end-of-frame flag).
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        AWAIT,
        DROP
    } rx_state_t;

    function automatic int entry_w(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame store: synchronous write, combinational read, and a
// separate port that marks an already-written entry as end-of-frame.
module rx_frame_ram
    import rx_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr,
    input  logic [DATA_W+DATA_W/8-1:0]    wr_data,
    input  logic                          eof_en,
    input  logic [$clog2(DEPTH)-1:0]      eof_addr,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [entry_w(DATA_W)-1:0]    rd_data
);

    logic [DATA_W+DATA_W/8-1:0] mem     [DEPTH];
    logic                       eof_mem [DEPTH];

    // A fresh word always starts with eof clear; the end strobe marks it later.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr]     <= wr_data;
            eof_mem[wr_addr] <= 1'b0;
        end
        if (eof_en) begin
            eof_mem[eof_addr] <= 1'b1;
        end
    end

    assign rd_data = {eof_mem[rd_addr], mem[rd_addr]};

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward RX buffer: frames stay uncommitted until the CRC verdict,
// bad or overflowed frames are rewound. RXFIFO_STATS_EN adds frame counters.
module rx_frame_fifo
    import rx_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 16
) (
    input  logic                     rxclk_180,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        rxd,
    input  logic [DATA_W/8-1:0]      rxc_fifo,
    input  logic                     receiving,
    input  logic                     recv_end,
    input  logic                     crc_done,
    input  logic                     crc_good,
    input  logic                     rx_ready,
    output logic [DATA_W-1:0]        rx_data,
    output logic [DATA_W/8-1:0]      rx_data_valid,
    output logic                     rx_eof,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
`ifdef RXFIFO_STATS_EN
    ,
    output logic [CNT_W-1:0]         good_frames,
    output logic [CNT_W-1:0]         dropped_frames
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = DATA_W / 8;
    localparam int EW = entry_w(DATA_W);

    rx_state_t         state, state_nxt;
    logic [PW-1:0]     wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]     commit_ptr, commit_ptr_nxt;
    logic [PW-1:0]     rd_ptr;
    logic [AW-1:0]     eof_addr;
    logic [EW-1:0]     rd_entry;
    logic              we, full, empty, load, out_full;
    logic              ram_we, eof_we, set_ovf;

    assign we         = receiving & ~recv_end;
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == PW'(DEPTH));
    assign empty      = (rd_ptr == commit_ptr);
    assign load       = ~empty & (~out_full | rx_ready);
    assign eof_addr   = wr_ptr[AW-1:0] - AW'(1);

    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        ram_we         = 1'b0;
        eof_we         = 1'b0;
        set_ovf        = 1'b0;
        case (state)
            IDLE, RECV: begin
                if (state == RECV && recv_end) begin
                    eof_we    = 1'b1;
                    state_nxt = AWAIT;
                end else if (we && full) begin
                    wr_ptr_nxt = commit_ptr;
                    set_ovf    = 1'b1;
                    state_nxt  = DROP;
                end else if (we) begin
                    ram_we     = 1'b1;
                    wr_ptr_nxt = wr_ptr + PW'(1);
                    state_nxt  = RECV;
                end
            end
            // A word arriving with the verdict starts a frame whose head is lost.
            AWAIT: begin
                if (crc_done) begin
                    if (crc_good) commit_ptr_nxt = wr_ptr;
                    else          wr_ptr_nxt     = commit_ptr;
                    state_nxt = we ? DROP : IDLE;
                end else if (we) begin
                    wr_ptr_nxt = commit_ptr;
                    state_nxt  = DROP;
                end
            end
            DROP: begin
                if (crc_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rxclk_180 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            overflow   <= overflow | set_ovf;
        end
    end

    // A consumed word with nothing behind it clears the outputs to "no word".
    always_ff @(posedge rxclk_180 or negedge reset) begin
        if (!reset) begin
            rd_ptr        <= '0;
            out_full      <= 1'b0;
            rx_data       <= '0;
            rx_data_valid <= '0;
            rx_eof        <= 1'b0;
        end else if (load) begin
            rd_ptr        <= rd_ptr + PW'(1);
            out_full      <= 1'b1;
            rx_data       <= rd_entry[DATA_W-1:0];
            rx_data_valid <= rd_entry[DATA_W+LW-1:DATA_W];
            rx_eof        <= rd_entry[EW-1];
        end else if (rx_ready) begin
            out_full      <= 1'b0;
            rx_data       <= '0;
            rx_data_valid <= '0;
            rx_eof        <= 1'b0;
        end
    end

    rx_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (rxclk_180),
        .wr_en    (ram_we),
        .wr_addr  (wr_ptr[AW-1:0]),
        .wr_data  ({rxc_fifo, rxd}),
        .eof_en   (eof_we),
        .eof_addr (eof_addr),
        .rd_addr  (rd_ptr[AW-1:0]),
        .rd_data  (rd_entry)
    );

`ifdef RXFIFO_STATS_EN
    logic              good_evt, bad_evt, drop_evt;
    logic [CNT_W:0]    drop_sum;

    assign good_evt = (state == AWAIT) & crc_done & crc_good;
    assign bad_evt  = (state == AWAIT) & crc_done & ~crc_good;
    assign drop_evt = set_ovf | ((state == AWAIT) & we);
    assign drop_sum = {1'b0, dropped_frames} + (CNT_W+1)'(bad_evt) + (CNT_W+1)'(drop_evt);

    always_ff @(posedge rxclk_180 or negedge reset) begin
        if (!reset) begin
            good_frames    <= '0;
            dropped_frames <= '0;
        end else begin
            if (good_evt && good_frames != '1) good_frames <= good_frames + CNT_W'(1);
            dropped_frames <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Randomised bench for rx_frame_fifo: expected output words are kept in a
// queue of committed frames, filled from the frame-level accept/drop rules.
module tb_rx_frame_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rxd = '0;
    logic [7:0]  rxc_fifo = '0;
    logic        receiving = 1'b0, recv_end = 1'b0, crc_done = 1'b0, crc_good = 1'b0;
    logic        rx_ready = 1'b0;
    logic [63:0] rx_data;
    logic [7:0]  rx_data_valid;
    logic        rx_eof;
    logic [4:0]  fifo_level;
    logic        overflow;
`ifdef RXFIFO_STATS_EN
    logic [15:0] good_frames, dropped_frames;
`endif

    int          total = 0, bad = 0;
    int          good_cnt = 0, drop_cnt = 0;
    int          ready_mode = 0;
    logic [79:0] exp_q[$];
    logic [79:0] first_word;
    logic [79:0] prev_word = '0;
    bit          prev_hold = 1'b0;
    logic [4:0]  lvl_await;

    rx_frame_fifo #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .rxclk_180     (clk),
        .reset         (reset),
        .rxd           (rxd),
        .rxc_fifo      (rxc_fifo),
        .receiving     (receiving),
        .recv_end      (recv_end),
        .crc_done      (crc_done),
        .crc_good      (crc_good),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_eof        (rx_eof),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
`ifdef RXFIFO_STATS_EN
        ,
        .good_frames    (good_frames),
        .dropped_frames (dropped_frames)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic rcv, input logic rend, input logic cdone,
                                 input logic cgood, input logic [63:0] d, input logic [7:0] c);
        @(posedge clk);
        #1;
        receiving = rcv;
        recv_end  = rend;
        crc_done  = cdone;
        crc_good  = cgood;
        rxd       = d;
        rxc_fifo  = c;
    endtask

    // Client back-pressure: 0 hold off, 1 always ready, 2 toggle, 3 random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                2:       rx_ready = ~rx_ready;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        logic [79:0] cur;
        cur = {7'b0, rx_eof, rx_data_valid, rx_data};
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) checkOutput("stable", cur, prev_word);
            if (rx_data_valid != 8'h00 && rx_ready) begin
                if (exp_q.size() == 0) checkOutput("unexpected", cur, 80'h0);
                else                   checkOutput("word", cur, exp_q.pop_front());
            end
            prev_hold = (rx_data_valid != 8'h00) && !rx_ready;
            prev_word = cur;
        end
    end

    // One whole frame plus its verdict; the model decides the frame's fate up front.
    task automatic send_frame(input int len, input bit good, input int crc_gap,
                              input logic [7:0] last_lanes, input bit chk_lat);
        logic [79:0] words[$];
        logic [63:0] d;
        logic [7:0]  c;
        int          stored;
        bit          fits;
        stored = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
        fits   = (len <= DEPTH - stored);
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom};
            c = (i == len - 1) ? last_lanes : 8'hFF;
            words.push_back({7'b0, (i == len - 1), c, d});
            applyStimulus(1, 0, 0, 0, d, c);
        end
        applyStimulus(1, 1, 0, 0, {$urandom, $urandom}, 8'hFF);
        for (int k = 1; k < crc_gap; k++) applyStimulus(0, 0, 0, 0, 64'h0, 8'h00);
        @(negedge clk);
        lvl_await = fifo_level;
        applyStimulus(0, 0, 1, good, 64'h0, 8'h00);
        if (good && fits) begin
            first_word = words[0];
            foreach (words[j]) exp_q.push_back(words[j]);
            good_cnt++;
        end else begin
            drop_cnt++;
        end
        applyStimulus(0, 0, 0, 0, 64'h0, 8'h00);
        if (chk_lat) begin
            @(negedge clk);
            checkOutput("lat_edge_e", rx_data_valid, 8'h00);
            @(negedge clk);
            checkOutput("lat_edge_e1", {7'b0, rx_eof, rx_data_valid, rx_data}, first_word);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 80'(exp_q.size()), 80'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stats();
`ifdef RXFIFO_STATS_EN
        checkOutput("good_frames", good_frames, 80'(good_cnt));
        checkOutput("dropped_frames", dropped_frames, 80'(drop_cnt));
`endif
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data", rx_data, 80'h0);
        checkOutput("rst_valid", rx_data_valid, 80'h0);
        checkOutput("rst_eof", rx_eof, 80'h0);
        checkOutput("rst_level", fifo_level, 80'h0);
        checkOutput("rst_overflow", overflow, 80'h0);
        check_stats();
        reset = 1'b1;

        $display("[TB] good frame");
        ready_mode = 1;
        send_frame(8, 1, 3, 8'h0F, 1);
        wait_drain();
        check_stats();

        $display("[TB] bad crc");
        send_frame(8, 0, 3, 8'h0F, 0);
        checkOutput("level_await", lvl_await, 80'd8);
        @(negedge clk);
        checkOutput("level_after_bad", fifo_level, 80'd0);
        wait_drain();
        check_stats();

        $display("[TB] overflow");
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send_frame(4, 1, 3, 8'hFF, 0);
        send_frame(20, 1, 3, 8'h0F, 0);
        checkOutput("level_in_drop", lvl_await, 80'd3);
        checkOutput("level_after_ovf", fifo_level, 80'd3);
        checkOutput("overflow_set", overflow, 80'd1);
        send_frame(4, 1, 3, 8'h3C, 0);
        ready_mode = 1;
        wait_drain();
        check_stats();

        $display("[TB] back-pressure");
        ready_mode = 2;
        send_frame(5, 1, 2, 8'h07, 0);
        send_frame(6, 1, 4, 8'hF0, 0);
        wait_drain();

        $display("[TB] wrap-around");
        ready_mode = 1;
        for (int f = 0; f < 10; f++) send_frame(7, 1, 3, 8'($urandom_range(1, 255)), 0);
        wait_drain();
        check_stats();

        $display("[TB] random frames");
        ready_mode = 3;
        for (int f = 0; f < 24; f++) begin
            send_frame($urandom_range(1, DEPTH + 4), ($urandom_range(0, 3) != 0),
                       $urandom_range(1, 4), 8'($urandom_range(1, 255)), 0);
            ready_mode = 1;
            wait_drain();
            ready_mode = 3;
        end
        check_stats();

        $display("[TB] reset mid-frame");
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send_frame(3, 1, 3, 8'h07, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, {$urandom, $urandom}, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        receiving = 1'b0;
        rxd = '0;
        rxc_fifo = '0;
        #1;
        exp_q.delete();
        good_cnt = 0;
        drop_cnt = 0;
        checkOutput("mid_rst_data", rx_data, 80'h0);
        checkOutput("mid_rst_valid", rx_data_valid, 80'h0);
        checkOutput("mid_rst_eof", rx_eof, 80'h0);
        checkOutput("mid_rst_level", fifo_level, 80'h0);
        checkOutput("mid_rst_overflow", overflow, 80'h0);
        check_stats();
        @(posedge clk);
        #1;
        reset = 1'b1;
        ready_mode = 1;
        send_frame(5, 1, 3, 8'h1F, 0);
        wait_drain();
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
